// File: rtl/cfg_port_pkg.sv
// ---------------------------------------------------------------------------
// cfg_port_pkg
// Shared definitions for the configuration ports (SPI, UART, bit-bang):
//   WORD_W      - configuration word width
//   SYNC_KEY    - default key that must be seen before data words stream
//   cfg_state_e - port state: IDLE (deselected), HUNT (searching for the
//                 key), STREAM (forwarding data words)
// ---------------------------------------------------------------------------
package cfg_port_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] SYNC_KEY = 32'hFAB0_FAB1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        STREAM = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/cfg_sync.sv
// ---------------------------------------------------------------------------
// cfg_sync
// N-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset (all flops clear to 0)
//   d_i    - asynchronous input
//   q_o    - synchronised output, Stages clocks of latency
// ---------------------------------------------------------------------------
module cfg_sync #(
    parameter int Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/config_spi_port.sv
// ---------------------------------------------------------------------------
// config_spi_port
// SPI mode-0 slave that deserialises 32-bit configuration words into the
// CLK domain. Data words are only forwarded once the sync key has been seen
// (bit-aligned, sliding match) in the current chip-select session.
//
// Output handshake: WriteStrobe is a one-cycle valid with no ready/backpressure.
// WriteData is valid in the strobe cycle and stays stable until the next
// strobe; the consumer must take the word in the strobe cycle.
//
// Ports:
//   CLK         - fabric clock
//   Reset_n     - asynchronous active-low reset
//   SCK         - SPI clock (asynchronous to CLK, each phase >= 2 CLK periods)
//   CSn         - SPI chip select, active low
//   MOSI        - serial data in, MSB first
//   MISO        - serial data out: previous data word, MSB first
//   WriteData   - last completed data word
//   WriteStrobe - one-CLK pulse per completed data word
//   Active      - high while streaming (key matched, CSn still low)
//   WordCount   - data words since last key match, saturating
//   StateDbg    - current FSM state (cfg_state_e encoding), debug only
// ---------------------------------------------------------------------------
module config_spi_port
    import cfg_port_pkg::*;
#(
    parameter logic [WORD_W-1:0] SyncKey    = SYNC_KEY,
    parameter int                SyncStages = 2
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              SCK,
    input  logic              CSn,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] WriteData,
    output logic              WriteStrobe,
    output logic              Active,
    output logic [15:0]       WordCount,
    output logic [1:0]        StateDbg
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_HUNT   = 2'(HUNT);
    localparam logic [1:0] S_STREAM = 2'(STREAM);

    logic sck_s, csn_s, mosi_s;

    cfg_sync #(.Stages(SyncStages)) u_sync_sck (
        .clk_i (CLK), .rst_ni (Reset_n), .d_i (SCK),  .q_o (sck_s)
    );
    cfg_sync #(.Stages(SyncStages)) u_sync_csn (
        .clk_i (CLK), .rst_ni (Reset_n), .d_i (CSn),  .q_o (csn_s)
    );
    cfg_sync #(.Stages(SyncStages)) u_sync_mosi (
        .clk_i (CLK), .rst_ni (Reset_n), .d_i (MOSI), .q_o (mosi_s)
    );

    // Edge detection works on two registered copies of the synchronised SCK.
    // MOSI is delayed by the same one stage so the bit used on a rise is the
    // value that was present at that SCK edge. CSn is used straight from its
    // synchroniser, so a CSn rise reaches the FSM no later than a coincident
    // SCK edge and always takes priority.
    logic sck_d1_q, sck_d2_q, mosi_d1_q;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sck_d1_q  <= 1'b0;
            sck_d2_q  <= 1'b0;
            mosi_d1_q <= 1'b0;
        end else begin
            sck_d1_q  <= sck_s;
            sck_d2_q  <= sck_d1_q;
            mosi_d1_q <= mosi_s;
        end
    end

    logic sck_rise, sck_fall;
    assign sck_rise = sck_d1_q & ~sck_d2_q;
    assign sck_fall = ~sck_d1_q & sck_d2_q;

    logic [1:0]        state_q,  state_d;
    logic [WORD_W-1:0] shift_q,  shift_d;
    logic [WORD_W-1:0] wdata_q,  wdata_d;
    logic [WORD_W-1:0] hold_q,   hold_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [15:0]       wcount_q, wcount_d;
    logic              strobe_q, strobe_d;
    logic              miso_q,   miso_d;
    logic [WORD_W-1:0] shift_next;

    assign shift_next = {shift_q[WORD_W-2:0], mosi_d1_q};

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        bitcnt_d = bitcnt_q;
        wcount_d = wcount_q;
        strobe_d = 1'b0;
        miso_d   = miso_q;

        if (csn_s) begin
            // Deselect aborts any partial word; WriteData/WordCount hold.
            state_d  = S_IDLE;
            shift_d  = '0;
            bitcnt_d = '0;
            miso_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_HUNT;
                end
                S_HUNT: begin
                    if (sck_rise) begin
                        shift_d = shift_next;
                        if (shift_next == SyncKey) begin
                            state_d  = S_STREAM;
                            bitcnt_d = '0;
                            wcount_d = '0;
                        end
                    end
                end
                S_STREAM: begin
                    if (sck_rise) begin
                        shift_d  = shift_next;
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd31) begin
                            wdata_d  = shift_next;
                            hold_d   = shift_next;
                            strobe_d = 1'b1;
                            if (wcount_q != 16'hFFFF) begin
                                wcount_d = wcount_q + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Read-back path: a rise and a fall never occur in the same
            // cycle, so this never collides with the hold load above.
            if (sck_fall) begin
                miso_d = hold_q[WORD_W-1];
                hold_d = {hold_q[WORD_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            wdata_q  <= '0;
            hold_q   <= '0;
            bitcnt_q <= '0;
            wcount_q <= '0;
            strobe_q <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            bitcnt_q <= bitcnt_d;
            wcount_q <= wcount_d;
            strobe_q <= strobe_d;
            miso_q   <= miso_d;
        end
    end

    assign MISO        = miso_q;
    assign WriteData   = wdata_q;
    assign WriteStrobe = strobe_q;
    assign Active      = (state_q == S_STREAM);
    assign WordCount   = wcount_q;
    assign StateDbg    = state_q;

endmodule

// File: tb/tb_config_spi_port.sv
// ---------------------------------------------------------------------------
// tb_config_spi_port
// Self-checking bench for config_spi_port. Each chip-select session is built
// as a bit list; the reference model scans that list for the key and cuts
// the remainder into words, pushing expected {WordCount, WriteData} entries
// into exp_q. A monitor pops one entry per WriteStrobe.
// ---------------------------------------------------------------------------
module tb_config_spi_port;

    localparam int          SYNC = 2;
    localparam int          HP   = 6;   // SCK half period in CLK cycles
    localparam logic [31:0] KEY  = 32'hFAB0_FAB1;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        SCK;
    logic        CSn;
    logic        MOSI;
    logic        MISO;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        Active;
    logic [15:0] WordCount;
    logic [1:0]  StateDbg;

    config_spi_port dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .SCK         (SCK),
        .CSn         (CSn),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .WriteData   (WriteData),
        .WriteStrobe (WriteStrobe),
        .Active      (Active),
        .WordCount   (WordCount),
        .StateDbg    (StateDbg)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q[$];
    bit          stim_bits[$];
    bit          miso_cap[$];
    logic [31:0] last_word = '0;
    logic [15:0] last_wc   = '0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic        strobe_prev;
        logic [47:0] e;
        strobe_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (Reset_n === 1'b1 && WriteStrobe === 1'b1) begin
                check("strobe_width", 48'(strobe_prev), 48'(0));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual=%0h expected=none", WriteData);
                end else begin
                    e = exp_q.pop_front();
                    check("write_data", 48'(WriteData), 48'(e[31:0]));
                    check("word_count", 48'(WordCount), 48'(e[47:32]));
                end
            end
            strobe_prev = WriteStrobe;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) stim_bits.push_back(w[i]);
    endtask

    task automatic push_rand_bits(input int n);
        for (int i = 0; i < n; i++) stim_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    // kind 1: check Active latency after this rise; kind 2: WriteStrobe latency
    task automatic spi_bit(input bit b, input int kind);
        MOSI = b;
        wait_clk(HP);
        miso_cap.push_back(MISO);
        SCK = 1'b1;
        if (kind == 1) begin
            wait_clk(SYNC + 1);
            check("active_lat_early", 48'(Active), 48'(0));
            wait_clk(1);
            check("active_lat", 48'(Active), 48'(1));
            wait_clk(HP - SYNC - 2);
        end else if (kind == 2) begin
            wait_clk(SYNC + 1);
            check("strobe_lat_early", 48'(WriteStrobe), 48'(0));
            wait_clk(1);
            check("strobe_lat", 48'(WriteStrobe), 48'(1));
            wait_clk(HP - SYNC - 2);
        end else begin
            wait_clk(HP);
        end
        SCK = 1'b0;
    endtask

    // Drives stim_bits as one CSn session; model expectations are pushed first.
    task automatic run_session(input int probe_a, input int probe_s, input bit do_reset);
        int          n;
        int          key_end;
        int          idx;
        bit          synced;
        logic [31:0] w;
        logic [31:0] words[$];

        n       = stim_bits.size();
        key_end = -1;
        for (int i = 31; i < n && key_end < 0; i++) begin
            for (int j = 0; j < 32; j++) w[31-j] = stim_bits[i-31+j];
            if (w == KEY) key_end = i;
        end
        synced = (key_end >= 0);
        if (synced) begin
            for (int s = key_end + 1; s + 31 < n; s += 32) begin
                for (int j = 0; j < 32; j++) w[31-j] = stim_bits[s+j];
                words.push_back(w);
                exp_q.push_back({16'(words.size()), w});
            end
        end

        miso_cap.delete();
        CSn = 1'b0;
        wait_clk(SYNC + 2 + HP);
        for (int i = 0; i < n; i++) begin
            spi_bit(stim_bits[i], (i == probe_a) ? 1 : ((i == probe_s) ? 2 : 0));
        end

        if (do_reset) begin
            Reset_n = 1'b0;
            #1;
            check("rst_mid_miso",   48'(MISO),        48'(0));
            check("rst_mid_wdata",  48'(WriteData),   48'(0));
            check("rst_mid_strobe", 48'(WriteStrobe), 48'(0));
            check("rst_mid_active", 48'(Active),      48'(0));
            check("rst_mid_wcount", 48'(WordCount),   48'(0));
            wait_clk(3);
            Reset_n   = 1'b1;
            CSn       = 1'b1;
            last_word = '0;
            last_wc   = '0;
            wait_clk(SYNC + 4);
            check("strobe_drain", 48'(exp_q.size()), 48'(0));
            exp_q.delete();
            return;
        end

        wait_clk(HP);
        check("active_streaming", 48'(Active), 48'(synced));
        CSn = 1'b1;
        wait_clk(SYNC + 3);
        check("active_low", 48'(Active), 48'(0));
        check("miso_idle",  48'(MISO),   48'(0));
        if (words.size() > 0) last_word = words[words.size()-1];
        if (synced) last_wc = 16'(words.size());
        check("wdata_hold",  48'(WriteData), 48'(last_word));
        check("wcount_hold", 48'(WordCount), 48'(last_wc));
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) wait_clk(1);
        check("strobe_drain", 48'(exp_q.size()), 48'(0));
        exp_q.delete();

        // While word k streams in, MISO carries word k-1 MSB first.
        if (synced) begin
            for (int k = 1; k <= words.size(); k++) begin
                for (int j = 0; j < 32; j++) begin
                    idx = key_end + 1 + 32 * k + j;
                    if (idx < n) check("miso_readback", 48'(miso_cap[idx]), 48'(words[k-1][31-j]));
                end
            end
        end
        wait_clk(4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] k;
        k       = KEY;
        Reset_n = 1'b0;
        CSn     = 1'b1;
        SCK     = 1'b0;
        MOSI    = 1'b0;
        wait_clk(3);
        check("rst_miso",   48'(MISO),        48'(0));
        check("rst_wdata",  48'(WriteData),   48'(0));
        check("rst_strobe", 48'(WriteStrobe), 48'(0));
        check("rst_active", 48'(Active),      48'(0));
        check("rst_wcount", 48'(WordCount),   48'(0));
        check("rst_state",  48'(StateDbg),    48'(0));
        Reset_n = 1'b1;
        wait_clk(5);

        // key then one data word, with latency probes
        stim_bits.delete();
        push_word(KEY);
        push_word(32'h1234_5678);
        run_session(31, 63, 1'b0);

        // no key: nothing forwarded
        stim_bits.delete();
        push_word(32'hDEAD_BEEF);
        push_word(32'h1234_5678);
        run_session(-1, -1, 1'b0);

        // two words, second checks MISO read-back of the first
        stim_bits.delete();
        push_word(KEY);
        push_word(32'hAAAA_AAAA);
        push_word(32'h5555_5555);
        run_session(-1, -1, 1'b0);

        // partial trailing word is discarded
        stim_bits.delete();
        push_word(KEY);
        push_word(32'h1111_1111);
        push_rand_bits(20);
        run_session(-1, -1, 1'b0);

        // misaligned: three key-prefix bits before the key
        stim_bits.delete();
        stim_bits.push_back(k[31]);
        stim_bits.push_back(k[30]);
        stim_bits.push_back(k[29]);
        push_word(KEY);
        push_word($urandom);
        run_session(-1, -1, 1'b0);

        // reset in the middle of a data word
        stim_bits.delete();
        push_word(KEY);
        push_rand_bits(16);
        run_session(-1, -1, 1'b1);

        // after reset the key is required again
        stim_bits.delete();
        push_word(32'h1234_5678);
        run_session(-1, -1, 1'b0);

        // randomized sessions
        for (int r = 0; r < 10; r++) begin
            int nw;
            stim_bits.delete();
            push_rand_bits($urandom_range(0, 40));
            if ($urandom_range(0, 3) != 0) push_word(KEY);
            nw = $urandom_range(0, 3);
            for (int i = 0; i < nw; i++) push_word($urandom);
            push_rand_bits($urandom_range(0, 31));
            run_session(-1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
